kex_sparse_packer: RTL and testbench
====================================

Name: kex_sparse_packer

Overview:
- Encoder counterpart of the 1*1 convolution's KEX reader.
- Accepts a dense stream of signed kernel weights, ordered kernel-major and then channel-major.
- Splits each kernel's Nif channels into groups of Npar and keeps at most Nnp nonzero weights per group.
- Writes each kept weight into KEX memory as a (weight, pos) pair, in exactly the layout the convolution engine consumes.

Parameters:
WG_W, 16, weight width (signed)
Npar, 8, channels per group (power of 2)
Nnp, 4, stored (weight,pos) entries per group
KEX_N_ELEM, 4096, KEX memory depth

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin packing; sampled only in IDLE
Nif  in  11  input channels per kernel; sampled on start
Nk  in  11  number of kernels; sampled on start
in_valid  in  1  dense weight valid
in_data  in  WG_W  dense weight (signed)
in_ready  out  1  packer accepts in_data this cycle
kex_addr  out  $clog2(KEX_N_ELEM)  KEX write address
kex_data  out  WG_W  weight written
kex_pos  out  $clog2(Npar)  position written
kex_write  out  1  KEX write strobe
finish  out  1  one-cycle done pulse
overflow  out  1  sticky: some group had more than Nnp nonzeros

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset mid-operation: abandons the current group immediately; no further kex_write; overflow cleared.
- Registered outputs: kex_addr, kex_data, kex_pos, kex_write, finish.
- in_ready is combinational from state: 1 only in COLLECT.
- States: IDLE, COLLECT, EMIT, FINISHED.
- IDLE:
  - on start, latch Nif and Nk; clear the group buffer and nonzero mask.
  - kex_addr <= 0; overflow <= 0.
  - go to COLLECT, or to FINISHED if Nif==0 or Nk==0.
  - start while not in IDLE is ignored.
- COLLECT:
  - handshake: a weight is consumed on in_valid && in_ready.
  - the r-th accepted weight of the group (r=0..) goes to buffer slot r; mask bit r is set if the weight is nonzero.
  - the group closes on the accept that makes r==Npar, or the accept that reaches channel Nif of the kernel; then go to EMIT.
  - group size g = number of weights accepted (g<Npar only for the last group of a kernel).
- EMIT: exactly Nnp cycles, one KEX write per cycle (kex_write=1).
  - each cycle select the lowest set mask bit j and clear it.
  - write kex_data=buf[j], kex_pos=(Npar-g)+j, so pos matches the shift-register index the convolution reads back.
  - if the mask is empty, write kex_data=0, kex_pos=0 (padding).
  - kex_addr increments by 1 after every write and wraps modulo KEX_N_ELEM.
  - after the Nnp-th write, a still-nonzero mask sets overflow; the excess weights are dropped.
- After EMIT:
  - next group of the same kernel: back to COLLECT.
  - else next kernel (channel count resets): back to COLLECT.
  - else after kernel Nk: go to FINISHED.
- FINISHED: finish=1 for one cycle, then IDLE.
- Memory layout: group n occupies addresses n*Nnp .. n*Nnp+Nnp-1.
- Groups per kernel = ceil(Nif/Npar).
- Throughput per group: g accepted cycles plus Nnp emit cycles; no input is accepted during EMIT.
- Weight zero test is exact equality to 0, with no thresholding.

Optional Feature:
- Macro: KEX_PACK_STATS_EN.
- When defined:
  - extra output nnz_count (width $clog2(KEX_N_ELEM)+1) counts real (non-padding) entries written.
  - extra output drop_count (16 bits, saturating) counts dropped nonzero weights.
  - both clear on reset and on accepted start.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Npar=8, Nnp=4, Nif=8, Nk=1; stream [0,3,0,0,-2,0,7,0] -> writes at addr 0..3 of (3,1),(-2,4),(7,6),(0,0); finish one cycle later; overflow=0.
- Same configuration; stream [1,2,3,4,5,6,7,8] -> writes (1,0),(2,1),(3,2),(4,3); overflow=1; with KEX_PACK_STATS_EN, drop_count=4 and nnz_count=4.
- Nif=11, Nk=2 (4 groups, addr 0..15); kernel 0 tail group [5,0,9] (g=3) -> addr 4..7 = (5,5),(9,7),(0,0),(0,0); kernel 1 starts at addr 8.
- Case 1 stream with in_valid asserted every other cycle -> identical writes and addresses; no write occurs during COLLECT.
- rst asserted during the 2nd EMIT cycle -> next cycle kex_write=0, kex_addr=0, overflow=0, state IDLE; a fresh start then reproduces case 1 exactly.
- start with Nk=0 -> no in_ready and no kex_write; finish pulses exactly 2 cycles after start.

Source files
------------

// File: rtl/kex_sparse_packer.sv
// Dense-to-sparse KEX weight packer: keeps up to Nnp nonzeros per Npar-channel group as (weight,pos) pairs.
// Optional KEX_PACK_STATS_EN adds nnz_count / drop_count statistics outputs.
module kex_sparse_packer #(
   parameter int WG_W       = 16,
   parameter int Npar       = 8,
   parameter int Nnp        = 4,
   parameter int KEX_N_ELEM = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [10:0]                   Nif,
   input  logic [10:0]                   Nk,
   input  logic                          in_valid,
   input  logic [WG_W-1:0]               in_data,
   output logic                          in_ready,
   output logic [$clog2(KEX_N_ELEM)-1:0] kex_addr,
   output logic [WG_W-1:0]               kex_data,
   output logic [$clog2(Npar)-1:0]       kex_pos,
   output logic                          kex_write,
   output logic                          finish,
   output logic                          overflow
`ifdef KEX_PACK_STATS_EN
   ,
   output logic [$clog2(KEX_N_ELEM):0]   nnz_count,
   output logic [15:0]                   drop_count
`endif
);

   localparam int AW = $clog2(KEX_N_ELEM);
   localparam int PW = $clog2(Npar);
   localparam int RW = $clog2(Npar + 1);
   localparam int EW = $clog2(Nnp + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_FINISHED} state_t;

   state_t            state_q, state_d;
   logic [10:0]       nif_q, nif_d, nk_q, nk_d;
   logic [10:0]       ch_q, ch_d, kern_q, kern_d;
   logic [RW-1:0]     r_q, r_d, g_q, g_d;
   logic [EW-1:0]     em_q, em_d;
   logic [Npar-1:0]   mask_q, mask_d;
   logic [WG_W-1:0]   wbuf_q [Npar];
   logic [WG_W-1:0]   wbuf_d [Npar];
   logic [AW-1:0]     addr_q, addr_d;
   logic [AW-1:0]     kex_addr_q, kex_addr_d;
   logic [WG_W-1:0]   kex_data_q, kex_data_d;
   logic [PW-1:0]     kex_pos_q, kex_pos_d;
   logic              kex_write_q, kex_write_d;
   logic              finish_q, finish_d;
   logic              overflow_q, overflow_d;
   logic [PW-1:0]     sel_j;
   logic              sel_vld;
   logic [RW-1:0]     left_n;
`ifdef KEX_PACK_STATS_EN
   logic [AW:0]       nnz_q, nnz_d;
   logic [15:0]       drop_q, drop_d;
   logic [16:0]       drop_sum;
`endif

   // Lowest set bit of the nonzero mask picks the next entry to emit.
   always_comb begin
      sel_j = '0;
      for (int i = Npar - 1; i >= 0; i--) begin
         if (mask_q[i]) sel_j = PW'(i);
      end
      sel_vld = |mask_q;
   end

   always_comb begin
      state_d     = state_q;
      nif_d       = nif_q;
      nk_d        = nk_q;
      ch_d        = ch_q;
      kern_d      = kern_q;
      r_d         = r_q;
      g_d         = g_q;
      em_d        = em_q;
      mask_d      = mask_q;
      wbuf_d      = wbuf_q;
      addr_d      = addr_q;
      kex_addr_d  = kex_addr_q;
      kex_data_d  = kex_data_q;
      kex_pos_d   = kex_pos_q;
      kex_write_d = 1'b0;
      finish_d    = 1'b0;
      overflow_d  = overflow_q;
      left_n      = '0;
`ifdef KEX_PACK_STATS_EN
      nnz_d       = nnz_q;
      drop_d      = drop_q;
      drop_sum    = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               nif_d      = Nif;
               nk_d       = Nk;
               ch_d       = '0;
               kern_d     = '0;
               r_d        = '0;
               mask_d     = '0;
               wbuf_d     = '{default: '0};
               addr_d     = '0;
               kex_addr_d = '0;
               overflow_d = 1'b0;
`ifdef KEX_PACK_STATS_EN
               nnz_d      = '0;
               drop_d     = '0;
`endif
               state_d    = (Nif == 11'd0 || Nk == 11'd0) ? S_FINISHED : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               wbuf_d[r_q[PW-1:0]] = in_data;
               mask_d[r_q[PW-1:0]] = (in_data != '0);
               r_d  = r_q + RW'(1);
               ch_d = ch_q + 11'd1;
               g_d  = r_q + RW'(1);
               if (r_q + RW'(1) == RW'(Npar) || ch_q + 11'd1 == nif_q) begin
                  em_d    = '0;
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            kex_write_d = 1'b1;
            kex_addr_d  = addr_q;
            addr_d      = addr_q + AW'(1);
            em_d        = em_q + EW'(1);
            if (sel_vld) begin
               kex_data_d     = wbuf_q[sel_j];
               // Short tail groups sit at the top of the reader's shift register.
               kex_pos_d      = PW'(Npar - int'(g_q) + int'(sel_j));
               mask_d[sel_j]  = 1'b0;
`ifdef KEX_PACK_STATS_EN
               nnz_d          = nnz_q + (AW + 1)'(1);
`endif
            end else begin
               kex_data_d = '0;
               kex_pos_d  = '0;
            end
            if (em_q == EW'(Nnp - 1)) begin
               for (int i = 0; i < Npar; i++) begin
                  left_n = left_n + RW'(mask_d[i]);
               end
               if (mask_d != '0) overflow_d = 1'b1;
`ifdef KEX_PACK_STATS_EN
               drop_sum = {1'b0, drop_q} + 17'(left_n);
               drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
               mask_d = '0;
               r_d    = '0;
               if (ch_q == nif_q) begin
                  if (kern_q + 11'd1 == nk_q) begin
                     state_d = S_FINISHED;
                  end else begin
                     kern_d  = kern_q + 11'd1;
                     ch_d    = '0;
                     state_d = S_COLLECT;
                  end
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_FINISHED: begin
            finish_d = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         nif_q       <= '0;
         nk_q        <= '0;
         ch_q        <= '0;
         kern_q      <= '0;
         r_q         <= '0;
         g_q         <= '0;
         em_q        <= '0;
         mask_q      <= '0;
         wbuf_q      <= '{default: '0};
         addr_q      <= '0;
         kex_addr_q  <= '0;
         kex_data_q  <= '0;
         kex_pos_q   <= '0;
         kex_write_q <= 1'b0;
         finish_q    <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef KEX_PACK_STATS_EN
         nnz_q       <= '0;
         drop_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         nif_q       <= nif_d;
         nk_q        <= nk_d;
         ch_q        <= ch_d;
         kern_q      <= kern_d;
         r_q         <= r_d;
         g_q         <= g_d;
         em_q        <= em_d;
         mask_q      <= mask_d;
         wbuf_q      <= wbuf_d;
         addr_q      <= addr_d;
         kex_addr_q  <= kex_addr_d;
         kex_data_q  <= kex_data_d;
         kex_pos_q   <= kex_pos_d;
         kex_write_q <= kex_write_d;
         finish_q    <= finish_d;
         overflow_q  <= overflow_d;
`ifdef KEX_PACK_STATS_EN
         nnz_q       <= nnz_d;
         drop_q      <= drop_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_COLLECT);
   assign kex_addr  = kex_addr_q;
   assign kex_data  = kex_data_q;
   assign kex_pos   = kex_pos_q;
   assign kex_write = kex_write_q;
   assign finish    = finish_q;
   assign overflow  = overflow_q;
`ifdef KEX_PACK_STATS_EN
   assign nnz_count  = nnz_q;
   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_kex_sparse_packer.sv
// Directed bench for kex_sparse_packer: hand-computed KEX write tables, timing and reset checks.
module tb_kex_sparse_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] nif_i = '0;
   logic [10:0] nk_i = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic [11:0] kex_addr;
   logic [15:0] kex_data;
   logic [2:0]  kex_pos;
   logic        kex_write;
   logic        finish;
   logic        overflow;
`ifdef KEX_PACK_STATS_EN
   logic [12:0] nnz_count;
   logic [15:0] drop_count;
`endif

   kex_sparse_packer dut (
      .clk(clk), .rst(rst), .start(start), .Nif(nif_i), .Nk(nk_i),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .kex_addr(kex_addr), .kex_data(kex_data), .kex_pos(kex_pos),
      .kex_write(kex_write), .finish(finish), .overflow(overflow)
`ifdef KEX_PACK_STATS_EN
      , .nnz_count(nnz_count), .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0, fin_n = 0, fin_cyc = 0, rdy_n = 0, ovl_n = 0, last_acc = 0, start_cyc = 0;
   int wa[$], wd[$], wp[$], wc[$];
   int stim[$];

   // Observation on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (kex_write) begin
         wa.push_back(int'(kex_addr));
         wd.push_back(int'($signed(kex_data)));
         wp.push_back(int'(kex_pos));
         wc.push_back(cyc);
      end
      if (finish) begin
         fin_n   <= fin_n + 1;
         fin_cyc <= cyc;
      end
      if (in_ready) rdy_n <= rdy_n + 1;
      if (in_ready && in_valid) last_acc <= cyc;
      if (in_ready && kex_write) ovl_n <= ovl_n + 1;
      if (start) start_cyc <= cyc;
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input int k, input int a, input int d, input int p);
      if (k < wa.size()) begin
         check_val($sformatf("wr%0d_addr", k), wa[k], a);
         check_val($sformatf("wr%0d_data", k), wd[k], d);
         check_val($sformatf("wr%0d_pos", k), wp[k], p);
      end else begin
         check_val($sformatf("wr%0d_present", k), 0, 1);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wp.delete(); wc.delete();
   endtask

   // Caller sits just after a rising edge.
   task automatic do_start(input int nif, input int nk);
      start = 1'b1;
      nif_i = 11'(nif);
      nk_i  = 11'(nk);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input int w, input int gap);
      bit ok;
      ok = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = 16'(w);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check_val("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_finish(input int fin0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (fin_n > fin0) break;
      end
      check_val("finish_seen", fin_n - fin0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run(input int nif, input int nk, input int gap);
      int fin0;
      fin0 = fin_n;
      clear_log();
      do_start(nif, nk);
      foreach (stim[i]) send(stim[i], gap);
      wait_finish(fin0);
   endtask

   task automatic check_case1(input string tag);
      check_val({tag, "_nwr"}, wa.size(), 4);
      check_wr(0, 0, 3, 1);
      check_wr(1, 1, -2, 4);
      check_wr(2, 2, 7, 6);
      check_wr(3, 3, 0, 0);
      if (wc.size() == 4) begin
         check_val({tag, "_fin_lat"}, fin_cyc - wc[3], 1);
         check_val({tag, "_wr_after_acc"}, int'(wc[0] > last_acc), 1);
         check_val({tag, "_wr_burst"}, wc[3] - wc[0], 3);
      end
      check_val({tag, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      int ovl0, rdy0, fin0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_write", int'(kex_write), 0);
      check_val("rst_addr", int'(kex_addr), 0);
      check_val("rst_finish", int'(finish), 0);
      check_val("rst_ovf", int'(overflow), 0);
      check_val("rst_ready", int'(in_ready), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Case 1: sparse single group.
      stim = '{0, 3, 0, 0, -2, 0, 7, 0};
      run(8, 1, 0);
      check_case1("c1");

      // Case 2: dense group overflows.
      stim = '{1, 2, 3, 4, 5, 6, 7, 8};
      run(8, 1, 0);
      check_val("c2_nwr", wa.size(), 4);
      check_wr(0, 0, 1, 0);
      check_wr(1, 1, 2, 1);
      check_wr(2, 2, 3, 2);
      check_wr(3, 3, 4, 3);
      check_val("c2_ovf", int'(overflow), 1);
`ifdef KEX_PACK_STATS_EN
      check_val("c2_drop", int'(drop_count), 4);
      check_val("c2_nnz", int'(nnz_count), 4);
`endif

      // Case 3: two kernels of 11 channels with short tail groups.
      stim = '{0, 1, 0, 0, 0, 0, 0, 2,  5, 0, 9,
               -1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4};
      run(11, 2, 0);
      check_val("c3_nwr", wa.size(), 16);
      check_wr(0, 0, 1, 1);
      check_wr(1, 1, 2, 7);
      check_wr(4, 4, 5, 5);
      check_wr(5, 5, 9, 7);
      check_wr(6, 6, 0, 0);
      check_wr(7, 7, 0, 0);
      check_wr(8, 8, -1, 0);
      check_wr(12, 12, 4, 7);
      check_wr(15, 15, 0, 0);
      check_val("c3_ovf", int'(overflow), 0);

      // Case 4: case 1 with a bubble between every valid.
      ovl0 = ovl_n;
      stim = '{0, 3, 0, 0, -2, 0, 7, 0};
      run(8, 1, 1);
      check_case1("c4");
      check_val("c4_wr_in_collect", ovl_n - ovl0, 0);

      // Case 5: reset lands in the second EMIT cycle.
      clear_log();
      do_start(8, 1);
      foreach (stim[i]) send(stim[i], 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (kex_write) break;
      end
      rst = 1'b1;
      @(negedge clk);
      check_val("r_write", int'(kex_write), 0);
      check_val("r_addr", int'(kex_addr), 0);
      check_val("r_ovf", int'(overflow), 0);
      check_val("r_ready", int'(in_ready), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_val("r_no_more_wr", wa.size(), 1);
      check_val("r_idle_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      run(8, 1, 0);
      check_case1("c5");

      // Case 6: Nk=0 finishes without touching memory.
      clear_log();
      rdy0 = rdy_n;
      fin0 = fin_n;
      do_start(8, 0);
      wait_finish(fin0);
      repeat (3) @(posedge clk);
      #1;
      check_val("c6_fin_lat", fin_cyc - start_cyc, 2);
      check_val("c6_fin_pulses", fin_n - fin0, 1);
      check_val("c6_ready", rdy_n - rdy0, 0);
      check_val("c6_nwr", wa.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
